// File: rtl/mem_bist_initiator.sv
// mem_bist_initiator
//   Request-side self-test master for a single-port req/ready memory.
//   A start command writes (seed + k) to words (base + k) for k = 0..len-1,
//   with the range wrapping at the top of the address space. It then reads the
//   range back, counts mismatches and reports pass/fail.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   start_i              start command (IDLE only)
//   base_addr_i, len_i   test range (len 0 = no-op)
//   seed_i               pattern seed
//   req_*_o, req_*_i     memory request interface
//   busy_o, done_o       test in progress / one-cycle end pulse
//   pass_o, err_count_o, first_fail_addr_o   result of the last test
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | waiting for start_i
// S_WR_REQ | write request for word k outstanding
// S_WR_GAP | one idle cycle after a write, advance k
// S_RD_REQ | read request for word k outstanding, compare on accept
// S_RD_GAP | one idle cycle after a read, advance k
// S_DONE   | done_o pulse cycle, results valid
module mem_bist_initiator #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic              req_o,
    output logic              req_rnw_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              req_ready_i,
    input  logic [DATA_W-1:0] req_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W:0]   err_count_o,
    output logic [ADDR_W-1:0] first_fail_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_GAP,
        S_RD_REQ,
        S_RD_GAP,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] k_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [DATA_W-1:0] seed_q;

    logic              req_q;
    logic              rnw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ADDR_W:0]   err_q;
    logic [ADDR_W-1:0] ffa_q;

    logic [ADDR_W-1:0] k_inc_d;
    logic [ADDR_W-1:0] addr_inc_d;
    logic [DATA_W-1:0] data_inc_d;
    logic [ADDR_W:0]   err_inc_d;
    logic              last_word;
    logic              mismatch;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    assign k_inc_d    = k_q + ONE;
    assign addr_inc_d = base_q + k_inc_d;
    assign data_inc_d = seed_q + DATA_W'(k_inc_d);
    assign err_inc_d  = err_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word  = (k_q == (len_q - ONE));
    // During reads the write-data register holds the expected pattern word.
    assign mismatch   = (req_rdata_i != wdata_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            base_q  <= '0;
            len_q   <= '0;
            seed_q  <= '0;
            req_q   <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffa_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        base_q <= base_addr_i;
                        len_q  <= len_i;
                        seed_q <= seed_i;
                        k_q    <= '0;
                        err_q  <= '0;
                        pass_q <= 1'b0;
                        ffa_q  <= '0;
                        busy_q <= 1'b1;
                        if (len_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= S_WR_REQ;
                            req_q   <= 1'b1;
                            rnw_q   <= 1'b0;
                            addr_q  <= base_addr_i;
                            wdata_q <= seed_i;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (req_ready_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_WR_GAP;
                    end
                end
                S_WR_GAP: begin
                    req_q <= 1'b1;
                    if (last_word) begin
                        k_q     <= '0;
                        state_q <= S_RD_REQ;
                        rnw_q   <= 1'b1;
                        addr_q  <= base_q;
                        wdata_q <= seed_q;
                    end else begin
                        k_q     <= k_inc_d;
                        state_q <= S_WR_REQ;
                        addr_q  <= addr_inc_d;
                        wdata_q <= data_inc_d;
                    end
                end
                S_RD_REQ: begin
                    if (req_ready_i) begin
                        req_q <= 1'b0;
                        if (mismatch) begin
                            err_q <= err_inc_d;
                            if (err_q == '0) begin
                                ffa_q <= addr_q;
                            end
                        end
                        if (last_word) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            // Include the final compare, which lands on this edge.
                            pass_q  <= (err_q == '0) && !mismatch;
                        end else begin
                            state_q <= S_RD_GAP;
                        end
                    end
                end
                S_RD_GAP: begin
                    k_q     <= k_inc_d;
                    req_q   <= 1'b1;
                    addr_q  <= addr_inc_d;
                    wdata_q <= data_inc_d;
                    state_q <= S_RD_REQ;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_o             = req_q;
    assign req_rnw_o         = rnw_q;
    assign req_addr_o        = addr_q;
    assign req_wdata_o       = wdata_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign err_count_o       = err_q;
    assign first_fail_addr_o = ffa_q;

endmodule

// File: tb/tb_mem_bist_initiator.sv
module tb_mem_bist_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [9:0]  len_i;
    logic [31:0] seed_i;
    logic        req_o;
    logic        req_rnw_o;
    logic [9:0]  req_addr_o;
    logic [31:0] req_wdata_o;
    logic        req_ready_i;
    logic [31:0] req_rdata_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [10:0] err_count_o;
    logic [9:0]  first_fail_addr_o;

    mem_bist_initiator dut (
        .clk               (clk),
        .reset             (reset),
        .start_i           (start_i),
        .base_addr_i       (base_addr_i),
        .len_i             (len_i),
        .seed_i            (seed_i),
        .req_o             (req_o),
        .req_rnw_o         (req_rnw_o),
        .req_addr_o        (req_addr_o),
        .req_wdata_o       (req_wdata_o),
        .req_ready_i       (req_ready_i),
        .req_rdata_i       (req_rdata_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .pass_o            (pass_o),
        .err_count_o       (err_count_o),
        .first_fail_addr_o (first_fail_addr_o)
    );

    always #5 clk = ~clk;

    // memory model
    logic [31:0] mem [0:1023];
    logic [9:0]  wlog_a [0:63];
    logic [31:0] wlog_d [0:63];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          stall_ctr = 0;
    int          delay_base = 0;
    bit          stall_w2 = 0;
    bit          flip_en = 0;

    assign req_ready_i = req_o && (stall_ctr == 0);
    assign req_rdata_i = mem[req_addr_o] ^
        {31'b0, flip_en && (req_addr_o == 10'h005 || req_addr_o == 10'h009)};

    always @(posedge clk) begin
        if (reset || (start_i && !busy_o)) begin
            wr_cnt <= 0;
            rd_cnt <= 0;
        end else if (req_o && req_ready_i) begin
            if (!req_rnw_o) begin
                mem[req_addr_o] <= req_wdata_o;
                if (wr_cnt < 64) begin
                    wlog_a[wr_cnt] <= req_addr_o;
                    wlog_d[wr_cnt] <= req_wdata_o;
                end
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
        if (!req_o)
            stall_ctr <= delay_base + ((stall_w2 && wr_cnt == 2) ? 5 : 0);
        else if (stall_ctr != 0)
            stall_ctr <= stall_ctr - 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // per-run observations
    int          r_cyc;
    bit          r_timeout;
    bit          r_anyreq;
    logic        r_busy_done;
    logic        r_busy_after;
    logic        req_hist [0:255];
    logic        rdy_hist [0:255];
    logic [9:0]  addr_hist [0:255];
    logic [31:0] wd_hist [0:255];

    // Called at a negedge; start_i is sampled on the following posedge (edge 0).
    task automatic run_bist(input logic [9:0] b, input logic [9:0] l, input logic [31:0] s,
                            input int p1, input int p2);
        base_addr_i = b;
        len_i       = l;
        seed_i      = s;
        start_i     = 1'b1;
        r_cyc       = 0;
        r_timeout   = 0;
        r_anyreq    = 0;
        while (1) begin
            @(posedge clk);
            @(negedge clk);
            r_cyc++;
            start_i = (r_cyc == p1 || r_cyc == p2);
            if (r_cyc < 256) begin
                req_hist[r_cyc]  = req_o;
                rdy_hist[r_cyc]  = req_ready_i;
                addr_hist[r_cyc] = req_addr_o;
                wd_hist[r_cyc]   = req_wdata_o;
            end
            if (req_o) r_anyreq = 1;
            if (done_o) break;
            if (r_cyc >= 2000) begin
                r_timeout = 1;
                break;
            end
        end
        start_i     = 1'b0;
        r_busy_done = busy_o;
        @(posedge clk);
        @(negedge clk);
        r_busy_after = busy_o;
    endtask

    function automatic bit wlog_ok(input logic [9:0] b, input logic [9:0] l, input logic [31:0] s);
        logic [9:0] a;
        logic [31:0] d;
        if (wr_cnt != int'(l) || rd_cnt != int'(l)) return 0;
        for (int i = 0; i < int'(l) && i < 64; i++) begin
            a = b + 10'(i);
            d = s + 32'(i);
            if (wlog_a[i] !== a || wlog_d[i] !== d) return 0;
        end
        return 1;
    endfunction

    typedef struct {
        logic [9:0]  base;
        logic [9:0]  len;
        logic [31:0] seed;
        int          dly;
        bit          flip;
        int          exp_cyc;
        bit          exp_pass;
        int          exp_err;
        logic [9:0]  exp_ffa;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{10'h3F0, 10'd32, 32'hA5A50000, 1, 0, 192, 1, 0, 10'h000};
        vecs[1] = '{10'h010, 10'd4,  32'h12345678, 0, 0, 16,  1, 0, 10'h000};
        vecs[2] = '{10'h000, 10'd16, 32'h00000000, 0, 1, 64,  0, 2, 10'h005};
        vecs[3] = '{10'h3FE, 10'd3,  32'hFFFFFFFF, 0, 0, 12,  1, 0, 10'h000};
        vecs[4] = '{10'h000, 10'd0,  32'h00000077, 0, 0, 1,   1, 0, 10'h000};
        vecs[5] = '{10'h004, 10'd8,  32'h0BADF00D, 1, 1, 48,  0, 2, 10'h005};
        vecs[6] = '{10'h3FF, 10'd1,  32'hDEADBEEF, 0, 0, 4,   1, 0, 10'h000};

        reset = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        len_i = '0;
        seed_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {req_o, req_rnw_o, req_addr_o, req_wdata_o, busy_o, done_o, pass_o,
               err_count_o, first_fail_addr_o}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            delay_base = vecs[i].dly;
            flip_en    = vecs[i].flip;
            run_bist(vecs[i].base, vecs[i].len, vecs[i].seed, -1, -1);
            check($sformatf("v%0d_timeout", i), r_timeout, 0);
            check($sformatf("v%0d_done_cycle", i), r_cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_busy_at_done", i), r_busy_done, 1);
            check($sformatf("v%0d_busy_after", i), r_busy_after, 0);
            check($sformatf("v%0d_pass", i), pass_o, vecs[i].exp_pass);
            check($sformatf("v%0d_err", i), err_count_o, vecs[i].exp_err);
            check($sformatf("v%0d_ffa", i), first_fail_addr_o, vecs[i].exp_ffa);
            check($sformatf("v%0d_traffic", i),
                  wlog_ok(vecs[i].base, vecs[i].len, vecs[i].seed), 1);
            if (vecs[i].len == 0)
                check("len0_no_req", r_anyreq, 0);
            if (vecs[i].exp_err != 0) begin
                repeat (5) @(negedge clk);
                check($sformatf("v%0d_hold", i), {pass_o, err_count_o, first_fail_addr_o},
                      {1'b0, 11'(vecs[i].exp_err), vecs[i].exp_ffa});
            end
        end
        flip_en = 0;
        delay_base = 0;

        // ready tied high: req toggles 1,0 every cycle
        begin
            bit ok;
            run_bist(10'h010, 10'd4, 32'h00000100, -1, -1);
            ok = 1;
            for (int c = 1; c <= 15; c++)
                if (req_hist[c] !== 1'(c % 2)) ok = 0;
            check("toggle_pattern", ok, 1);
            check("toggle_done_cycle", r_cyc, 16);
            check("toggle_busy_after", r_busy_after, 0);
        end

        // stall 5 cycles on write 2, with stray start pulses during the test
        begin
            bit ok;
            int stalls;
            stall_w2 = 1;
            run_bist(10'h000, 10'd8, 32'h00000055, 7, 20);
            stall_w2 = 0;
            ok = 1;
            stalls = 0;
            for (int c = 1; c < 40; c++) begin
                if (req_hist[c] && !rdy_hist[c]) begin
                    stalls++;
                    if (!req_hist[c+1] || addr_hist[c+1] !== addr_hist[c] ||
                        wd_hist[c+1] !== wd_hist[c]) ok = 0;
                end
            end
            check("stall_count", stalls, 5);
            check("stall_stable", ok, 1);
            check("stall_done_cycle", r_cyc, 37);
            check("stall_pass", pass_o, 1);
            check("stall_traffic", wlog_ok(10'h000, 10'd8, 32'h00000055), 1);
        end

        // reset during the third read of a len=8 test
        begin
            bit found;
            base_addr_i = 10'h020;
            len_i = 10'd8;
            seed_i = 32'h00001000;
            start_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            found = 0;
            for (int c = 0; c < 200; c++) begin
                if (req_o && req_rnw_o && rd_cnt == 2) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
            end
            check("reach_third_read", found, 1);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            check("midtest_reset_outputs",
                  {req_o, req_rnw_o, req_addr_o, req_wdata_o, busy_o, done_o, pass_o,
                   err_count_o, first_fail_addr_o}, 64'h0);
            run_bist(10'h020, 10'd8, 32'h00002000, -1, -1);
            check("restart_done_cycle", r_cyc, 32);
            check("restart_pass", pass_o, 1);
            check("restart_err", err_count_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
